// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register indices, field positions and exception codes
package cp0_pkg;
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;
    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int IP_HI   = 15;
    localparam int IP_LO   = 10;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;
    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction
endpackage

// File: rtl/cp0_ctrl_if.sv
// cp0_ctrl_if: M-stage pipeline <-> CP0 signal bundle
interface cp0_ctrl_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic        Req;
    modport master (output A1, A2, DIn, WE, PC, BDIn, ExcCodeIn, HWInt, EXLClr, input DOut, EPCOut, Req);
    modport slave  (input A1, A2, DIn, WE, PC, BDIn, ExcCodeIn, HWInt, EXLClr, output DOut, EPCOut, Req);
endinterface

// File: rtl/cp0_exc_arb.sv
// cp0_exc_arb: interrupt vs synchronous exception arbitration and code select
module cp0_exc_arb
    import cp0_pkg::*;
(
    input  logic       ie,
    input  logic       exl,
    input  logic [5:0] im,
    input  logic [5:0] hw_int,
    input  logic [4:0] exc_code_in,
    output logic       req,
    output logic [4:0] exc_code
);
    logic int_req;
    logic exc_req;
    // interrupts win over the pipe's exception; EXL masks both
    always_comb begin
        int_req  = ie & ~exl & (|(hw_int & im));
        exc_req  = ~exl & (exc_code_in != 5'd0);
        req      = int_req | exc_req;
        exc_code = int_req ? EXC_INT : exc_code_in;
    end
endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: CP0 register file (SR/Cause/EPC/PRId) and exception request at M
// Optional: define CP0_EPC_FWD_EN to forward an mtc0 EPC write onto EPCOut same-cycle.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID     = 32'h0000_0707,
    parameter logic [5:0]  IM_RESET = 6'b000000
) (
    input logic         clk,
    input logic         reset,
    cp0_ctrl_if.slave   bus
);
    logic [5:0]  im;
    logic [5:0]  ip;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic        req;
    logic [4:0]  arb_code;
    logic        mtc0;
    logic [31:0] victim_epc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    cp0_exc_arb u_arb (
        .ie          (ie),
        .exl         (exl),
        .im          (im),
        .hw_int      (bus.HWInt),
        .exc_code_in (bus.ExcCodeIn),
        .req         (req),
        .exc_code    (arb_code)
    );

    // a taken exception kills the M instruction, so its mtc0 must not land
    always_comb begin
        mtc0       = bus.WE & ~req;
        victim_epc = word_align(bus.PC) - (bus.BDIn ? 32'd4 : 32'd0);
    end

    // register file: exception entry has priority over mtc0; IP samples every edge
    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= IM_RESET;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= bus.HWInt;
            if (req) begin
                exl      <= 1'b1;
                bd       <= bus.BDIn;
                exc_code <= arb_code;
                epc      <= victim_epc;
            end else begin
                if (mtc0 && bus.A2 == REG_SR) begin
                    im  <= bus.DIn[IM_HI:IM_LO];
                    ie  <= bus.DIn[IE_BIT];
                    exl <= bus.DIn[EXL_BIT] & ~bus.EXLClr;
                end else if (bus.EXLClr) begin
                    exl <= 1'b0;
                end
                if (mtc0 && bus.A2 == REG_EPC)
                    epc <= word_align(bus.DIn);
            end
        end
    end

    // mfc0 read mux over pre-edge state; unimplemented bits read zero
    always_comb begin
        sr_word                      = '0;
        sr_word[IM_HI:IM_LO]         = im;
        sr_word[EXL_BIT]             = exl;
        sr_word[IE_BIT]              = ie;
        cause_word                   = '0;
        cause_word[BD_BIT]           = bd;
        cause_word[IP_HI:IP_LO]      = ip;
        cause_word[EXC_HI:EXC_LO]    = exc_code;
        bus.Req  = req;
        bus.DOut = bus.A1 == REG_SR    ? sr_word    :
                   bus.A1 == REG_CAUSE ? cause_word :
                   bus.A1 == REG_EPC   ? epc        :
                   bus.A1 == REG_PRID  ? PRID       : 32'd0;
`ifdef CP0_EPC_FWD_EN
        bus.EPCOut = (mtc0 && bus.A2 == REG_EPC) ? word_align(bus.DIn) : epc;
`else
        bus.EPCOut = epc;
`endif
    end
endmodule
